// File: rtl/calc_operand_sequencer.sv
// Button-stepped operand front-end for the ADDER: enters A, B and opcode,
// lets the datapath settle, then latches R/ovf for display.
module calc_operand_sequencer #(
   parameter int WIDTH  = 4,
   parameter int OPW    = 3,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic [OPW-1:0]   op_sw,
   input  logic             enter,
   input  logic             clear,
   output logic [WIDTH-1:0] V1,
   output logic [WIDTH-1:0] V2,
   output logic [OPW-1:0]   OP,
   input  logic [WIDTH-1:0] R_in,
   input  logic             ovf_in,
   output logic [WIDTH-1:0] result,
   output logic             result_ovf,
   output logic             result_valid,
   output logic             busy,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_GET_A  = 3'd0,
      S_GET_B  = 3'd1,
      S_GET_OP = 3'd2,
      S_SETTLE = 3'd3,
      S_SHOW   = 3'd4
   } state_t;

   localparam logic [3:0] CLOAD = 4'(SETTLE - 1);

   logic s1, s2, prev;
   logic enter_pulse;

   state_t           cur, nxt;
   logic [3:0]       cnt, cnt_n;
   logic [WIDTH-1:0] v1_n, v2_n, res_n;
   logic [OPW-1:0]   op_n;
   logic             rovf_n, rv_n, busy_n;

   // synchronizer survives clear so a held button cannot re-fire
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= enter;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign enter_pulse = s2 & ~prev;

   always_comb begin
      nxt    = cur;
      cnt_n  = cnt;
      v1_n   = V1;
      v2_n   = V2;
      op_n   = OP;
      res_n  = result;
      rovf_n = result_ovf;
      rv_n   = result_valid;
      busy_n = busy;
      if (clear) begin
         nxt    = S_GET_A;
         cnt_n  = '0;
         v1_n   = '0;
         v2_n   = '0;
         op_n   = '0;
         res_n  = '0;
         rovf_n = 1'b0;
         rv_n   = 1'b0;
         busy_n = 1'b0;
      end else begin
         unique case (cur)
            S_GET_A: if (enter_pulse) begin
               v1_n = sw;
               rv_n = 1'b0;
               nxt  = S_GET_B;
            end
            S_GET_B: if (enter_pulse) begin
               v2_n = sw;
               nxt  = S_GET_OP;
            end
            S_GET_OP: if (enter_pulse) begin
               op_n   = op_sw;
               cnt_n  = CLOAD;
               busy_n = 1'b1;
               nxt    = S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt == 4'd0) begin
                  res_n  = R_in;
                  rovf_n = ovf_in;
                  rv_n   = 1'b1;
                  busy_n = 1'b0;
                  nxt    = S_SHOW;
               end else begin
                  cnt_n = cnt - 4'd1;
               end
            end
            S_SHOW: if (enter_pulse) nxt = S_GET_A;
            default: nxt = S_GET_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur          <= S_GET_A;
         cnt          <= '0;
         V1           <= '0;
         V2           <= '0;
         OP           <= '0;
         result       <= '0;
         result_ovf   <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         cur          <= nxt;
         cnt          <= cnt_n;
         V1           <= v1_n;
         V2           <= v2_n;
         OP           <= op_n;
         result       <= res_n;
         result_ovf   <= rovf_n;
         result_valid <= rv_n;
         busy         <= busy_n;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Scoreboarded random/directed bench for calc_operand_sequencer
// with a behavioural ADDER attached to its operand outputs.
module tb_calc_operand_sequencer;

   localparam int ST = 4;

   typedef struct packed {
      logic [3:0] r;
      logic       o;
   } exp_t;

   logic       clk = 0;
   logic       rst_n = 0;
   logic       enter = 0;
   logic       clear = 0;
   logic [3:0] sw = 0;
   logic [2:0] op_sw = 0;
   logic [3:0] V1, V2, R_in, result;
   logic [2:0] OP, state;
   logic       ovf_in, result_ovf, result_valid, busy;

   calc_operand_sequencer #(.WIDTH(4), .OPW(3), .SETTLE(ST)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .op_sw(op_sw),
      .enter(enter), .clear(clear), .V1(V1), .V2(V2), .OP(OP),
      .R_in(R_in), .ovf_in(ovf_in), .result(result),
      .result_ovf(result_ovf), .result_valid(result_valid),
      .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   // ADDER stand-in: bit0 = subtract, bit2 = swap operands
   function automatic logic [4:0] adder(input logic [3:0] a, b,
                                        input logic [2:0] o);
      logic [3:0] x, y;
      x = o[2] ? b : a;
      y = o[2] ? a : b;
      if (o[0]) return {1'b0, x} + {1'b0, ~y} + 5'd1;
      return {1'b0, x} + {1'b0, y};
   endfunction

   always_comb {ovf_in, R_in} = adder(V1, V2, OP);

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t q[$];

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // monitor: pops the scoreboard whenever a new result appears
   logic [2:0] pst = 0;
   logic       pv = 0;
   int         t0 = 0;
   exp_t       e;

   always @(negedge clk) begin
      if (state == 3'd3 && pst == 3'd2) begin
         t0 = cyc;
         chk("busy_on", 32'(busy), 32'd1);
      end
      if (result_valid && !pv) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_capture: got %0h expected none",
                     result);
         end else begin
            e = q.pop_front();
            chk("result", 32'(result), 32'(e.r));
            chk("result_ovf", 32'(result_ovf), 32'(e.o));
            chk("latency", 32'(cyc - t0), 32'(ST));
            chk("show_state", 32'(state), 32'd4);
            chk("busy_off", 32'(busy), 32'd0);
         end
      end
      pst = state;
      pv  = result_valid;
   end

   // spec-level model of what should be visible
   int         es;
   logic [3:0] ev1, ev2, er;
   logic [2:0] eop;
   logic       eo, evalid;

   task automatic model_reset();
      es = 0; ev1 = 0; ev2 = 0; eop = 0;
      er = 0; eo = 0; evalid = 0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".state"}, 32'(state), 32'(es));
      chk({tag, ".V1"}, 32'(V1), 32'(ev1));
      chk({tag, ".V2"}, 32'(V2), 32'(ev2));
      chk({tag, ".OP"}, 32'(OP), 32'(eop));
      chk({tag, ".valid"}, 32'(result_valid), 32'(evalid));
      chk({tag, ".result"}, 32'(result), 32'(er));
      chk({tag, ".ovf"}, 32'(result_ovf), 32'(eo));
      chk({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hi, input int lo);
      enter = 1;
      tick(hi);
      enter = 0;
      tick(lo);
   endtask

   task automatic step(input logic [3:0] s, input logic [2:0] o,
                       input string tag);
      logic [4:0] ar;
      sw = s;
      op_sw = o;
      if (es == 2) begin
         ar = adder(ev1, ev2, o);
         q.push_back('{r: ar[3:0], o: ar[4]});
      end
      press(3, 4);
      case (es)
         0: begin ev1 = s; evalid = 0; es = 1; end
         1: begin ev2 = s; es = 2; end
         2: begin
            eop = o; ar = adder(ev1, ev2, o);
            er = ar[3:0]; eo = ar[4]; evalid = 1; es = 4;
         end
         default: es = 0;
      endcase
      chk_all(tag);
   endtask

   task automatic do_op(input logic [3:0] a, b, input logic [2:0] o);
      if (es == 4) step(4'($urandom), 3'($urandom), "to_a");
      step(a, 3'($urandom), "load_a");
      step(b, 3'($urandom), "load_b");
      step(4'($urandom), o, "load_op");
   endtask

   task automatic do_reset();
      rst_n = 0;
      tick(2);
      rst_n = 1;
      model_reset();
   endtask

   logic [4:0] ar2;

   initial begin
      model_reset();
      do_reset();
      chk_all("reset");

      do_op(4'd3, 4'd5, 3'd0);
      do_op(4'd5, 4'd3, 3'd1);
      do_op(4'd3, 4'd5, 3'd5);

      // held button gives a single pulse
      do_reset();
      sw = 4'd7;
      enter = 1;
      tick(20);
      enter = 0;
      tick(4);
      ev1 = 4'd7;
      es = 1;
      chk_all("hold");

      // presses during settle are dropped
      step(4'd2, 3'd0, "settle_b");
      op_sw = 3'd6;
      ar2 = adder(4'd7, 4'd2, 3'd6);
      q.push_back('{r: ar2[3:0], o: ar2[4]});
      repeat (3) begin
         enter = 1;
         tick(1);
         enter = 0;
         tick(1);
      end
      tick(6);
      eop = 3'd6; er = ar2[3:0]; eo = ar2[4]; evalid = 1; es = 4;
      chk_all("settle_ignore");

      // reset mid-settle aborts
      step(4'd0, 3'd0, "abort_to_a");
      step(4'd9, 3'd0, "abort_a");
      step(4'd4, 3'd0, "abort_b");
      op_sw = 3'd3;
      press(1, 3);
      chk("mid_state", 32'(state), 32'd3);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 0;
      tick(1);
      rst_n = 1;
      model_reset();
      chk_all("abort");
      tick(8);
      chk_all("abort_late");

      // clear beats a coincident pulse in GET_B
      step(4'd6, 3'd0, "clr_a");
      sw = 4'd11;
      enter = 1;
      tick(2);
      clear = 1;
      tick(1);
      clear = 0;
      tick(4);
      enter = 0;
      tick(4);
      model_reset();
      chk_all("clear");

      // overflow wrap, then valid persistence
      do_op(4'd8, 4'd8, 3'd0);
      step(4'd0, 3'd0, "show_to_a");
      chk("valid_kept", 32'(result_valid), 32'd1);
      step(4'd1, 3'd0, "next_a");
      chk("valid_drop", 32'(result_valid), 32'd0);
      step(4'd2, 3'd0, "fin_b");
      step(4'd0, 3'd2, "fin_op");

      for (int i = 0; i < 10; i++)
         do_op(4'($urandom), 4'($urandom), 3'($urandom));

      tick(6);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
